// File: rtl/sprite_compositor_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor_arbiter
// Purpose  : Priority compositor for N_SPRITES sprites over a background.
//            It produces one registered 3-bit VGA colour stream. The module
//            also detects pixel-accurate player/obstacle overlap and runs the
//            game-state machine (PLAY / CRASH / OVER). That machine keeps the
//            lives counter and blinks the player during a crash.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1            system clock
//   reset      in   1            asynchronous, active-high reset
//   video_on   in   1            current pixel is in the visible area
//   frame_tick in   1            one-cycle pulse at start of vertical blank
//   on_in      in   N_SPRITES    per-sprite coverage, bit i = sprite i
//   rgb_in     in   3*N_SPRITES  sprite colours, sprite i at [3i+2:3i]
//   rgb_bg     in   3            background colour
//   restart    in   1            leave OVER (level-sensitive)
//   rgb_out    out  3            composited colour, 1-cycle latency
//   collision  out  1            one-cycle pulse when a crash is registered
//   freeze     out  1            high in CRASH and OVER
//   lives      out  LIVES_W      remaining lives
//   state      out  2            00 PLAY, 01 CRASH, 10 OVER
// ============================================================================
module sprite_compositor_arbiter #(
  parameter int N_SPRITES    = 8,
  parameter int LIVES_INIT   = 3,
  parameter int LIVES_W      = 2,
  parameter int CRASH_FRAMES = 60,
  parameter int CNT_W        = 6,
  parameter int BLINK_BIT    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   video_on,
  input  logic                   frame_tick,
  input  logic [N_SPRITES-1:0]   on_in,
  input  logic [3*N_SPRITES-1:0] rgb_in,
  input  logic [2:0]             rgb_bg,
  input  logic                   restart,
  output logic [2:0]             rgb_out,
  output logic                   collision,
  output logic                   freeze,
  output logic [LIVES_W-1:0]     lives,
  output logic [1:0]             state
);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_CRASH = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

  localparam logic [LIVES_W-1:0] C_LIVES_RST = LIVES_W'(LIVES_INIT);
  localparam logic [CNT_W-1:0]   C_CNT_LAST  = CNT_W'(CRASH_FRAMES - 1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [LIVES_W-1:0]   lives_q, lives_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 hit_frame_q, hit_frame_d;
  logic [2:0]           rgb_q, rgb_d;

  // --------------------------------------------------------------------------
  // Compositing
  // --------------------------------------------------------------------------
  logic [N_SPRITES-1:0] eff_on;
  logic [2:0]           sel_rgb;

  // The player sprite is hidden while the blink bit of the crash counter is
  // set. This only affects what is drawn, never the hit detection below.
  always_comb begin
    eff_on = on_in;
    if ((state_q == ST_CRASH) && cnt_q[BLINK_BIT]) begin
      eff_on[0] = 1'b0;
    end
  end

  // Scan from the highest index down so the lowest set index is the last
  // assignment and therefore wins.
  always_comb begin
    sel_rgb = rgb_bg;
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (eff_on[i]) begin
        sel_rgb = rgb_in[3*i +: 3];
      end
    end
  end

  assign rgb_d = video_on ? sel_rgb : 3'b000;

  // --------------------------------------------------------------------------
  // Collision detection
  // --------------------------------------------------------------------------
  logic hit;
  logic frame_hit;
  logic collision_c;

  // Raw on_in[0] is used here so a blinking player still collides.
  assign hit       = video_on & on_in[0] & (|on_in[N_SPRITES-1:1]);
  // Including the live hit lets an overlap on the tick cycle itself count.
  assign frame_hit = hit_frame_q | hit;

  // --------------------------------------------------------------------------
  // Game-state machine: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    cnt_d       = cnt_q;
    hit_frame_d = hit_frame_q | hit;
    collision_c = 1'b0;

    // The sticky flag covers exactly one frame.
    if (frame_tick) begin
      hit_frame_d = 1'b0;
    end

    unique case (state_q)
      ST_PLAY: begin
        if (frame_tick && frame_hit) begin
          collision_c = 1'b1;
          // Guard keeps the counter from wrapping below zero.
          if (lives_q != '0) begin
            lives_d = lives_q - 1'b1;
          end
          cnt_d   = '0;
          state_d = ST_CRASH;
        end
      end

      ST_CRASH: begin
        if (frame_tick) begin
          if (cnt_q == C_CNT_LAST) begin
            cnt_d   = '0;
            state_d = (lives_q == '0) ? ST_OVER : ST_PLAY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_OVER: begin
        // restart is checked every clock, not only on frame ticks.
        if (restart) begin
          lives_d     = C_LIVES_RST;
          cnt_d       = '0;
          hit_frame_d = 1'b0;
          state_d     = ST_PLAY;
        end
      end

      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_PLAY;
      lives_q     <= C_LIVES_RST;
      cnt_q       <= '0;
      hit_frame_q <= 1'b0;
      rgb_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      hit_frame_q <= hit_frame_d;
      rgb_q       <= rgb_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign rgb_out   = rgb_q;
  // The collision pulse is combinational on the tick cycle. It is held low
  // during reset so the output matches its reset value immediately.
  assign collision = collision_c & ~reset;
  assign freeze    = (state_q != ST_PLAY);
  assign lives     = lives_q;
  assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_compositor_arbiter
// Purpose  : Directed self-checking bench for sprite_compositor_arbiter.
//            It uses the default parameters (8 sprites, 3 lives, 60 frames).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_compositor_arbiter;

  logic        clk;
  logic        reset;
  logic        video_on;
  logic        frame_tick;
  logic [7:0]  on_in;
  logic [23:0] rgb_in;
  logic [2:0]  rgb_bg;
  logic        restart;
  logic [2:0]  rgb_out;
  logic        collision;
  logic        freeze;
  logic [1:0]  lives;
  logic [1:0]  state;

  int total;
  int bad;

  sprite_compositor_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .video_on   (video_on),
    .frame_tick (frame_tick),
    .on_in      (on_in),
    .rgb_in     (rgb_in),
    .rgb_bg     (rgb_bg),
    .restart    (restart),
    .rgb_out    (rgb_out),
    .collision  (collision),
    .freeze     (freeze),
    .lives      (lives),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---- stimulus helpers (no checking inside) -------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    video_on   = 1'b0;
    frame_tick = 1'b0;
    on_in      = '0;
    rgb_in     = '0;
    rgb_bg     = 3'b000;
    restart    = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // One frame tick followed by one quiet cycle.
  task automatic do_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  // One visible overlap cycle, then a clean frame tick.
  task automatic crash_frame();
    video_on = 1'b1;
    on_in    = 8'b0000_0011;
    step();
    video_on   = 1'b0;
    on_in      = '0;
    frame_tick = 1'b1;
    #1;
  endtask

  // ---- tests -----------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    video_on = 1'b1;
    rgb_bg   = 3'b101;
    reset    = 1'b1;
    step();
    total++; if (rgb_out !== 3'b000) begin bad++; $display("FAIL reset_rgb got=%b exp=000", rgb_out); end
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL reset_collision got=%b exp=0", collision); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL reset_freeze got=%b exp=0", freeze); end
    total++; if (lives !== 2'd3) begin bad++; $display("FAIL reset_lives got=%0d exp=3", lives); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state got=%b exp=00", state); end
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  task automatic test_priority();
    apply_reset();
    rgb_in[5:3] = 3'b001;
    rgb_in[8:6] = 3'b100;
    on_in       = 8'b0000_0110;
    video_on    = 1'b1;
    step();
    total++; if (rgb_out !== 3'b001) begin bad++; $display("FAIL prio_s1_over_s2 got=%b exp=001", rgb_out); end
    video_on = 1'b0;
    step();
    total++; if (rgb_out !== 3'b000) begin bad++; $display("FAIL prio_blank got=%b exp=000", rgb_out); end
    on_in    = '0;
    rgb_bg   = 3'b010;
    video_on = 1'b1;
    step();
    total++; if (rgb_out !== 3'b010) begin bad++; $display("FAIL prio_bg got=%b exp=010", rgb_out); end
    rgb_in[11:9]  = 3'b011;
    rgb_in[17:15] = 3'b110;
    on_in         = 8'b0010_1000;
    step();
    total++; if (rgb_out !== 3'b011) begin bad++; $display("FAIL prio_s3_over_s5 got=%b exp=011", rgb_out); end
    rgb_in[23:21] = 3'b101;
    on_in         = 8'b1000_0000;
    step();
    total++; if (rgb_out !== 3'b101) begin bad++; $display("FAIL prio_s7_only got=%b exp=101", rgb_out); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL prio_no_crash got=%b exp=00", state); end
    idle_inputs();
    step();
  endtask

  task automatic test_crash_entry();
    apply_reset();
    video_on = 1'b1;
    on_in    = 8'b0000_0011;
    #1;
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL entry_no_pulse_before_tick got=%b exp=0", collision); end
    step();
    video_on   = 1'b0;
    on_in      = '0;
    frame_tick = 1'b1;
    #1;
    total++; if (collision !== 1'b1) begin bad++; $display("FAIL entry_pulse got=%b exp=1", collision); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL entry_freeze_on_tick got=%b exp=0", freeze); end
    step();
    frame_tick = 1'b0;
    #1;
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL entry_pulse_width got=%b exp=0", collision); end
    total++; if (lives !== 2'd2) begin bad++; $display("FAIL entry_lives got=%0d exp=2", lives); end
    total++; if (state !== 2'b01) begin bad++; $display("FAIL entry_state got=%b exp=01", state); end
    total++; if (freeze !== 1'b1) begin bad++; $display("FAIL entry_freeze got=%b exp=1", freeze); end
  endtask

  task automatic test_tick_hit();
    apply_reset();
    video_on   = 1'b1;
    on_in      = 8'b0100_0001;
    frame_tick = 1'b1;
    #1;
    total++; if (collision !== 1'b1) begin bad++; $display("FAIL tickhit_pulse got=%b exp=1", collision); end
    step();
    idle_inputs();
    #1;
    total++; if (lives !== 2'd2) begin bad++; $display("FAIL tickhit_lives got=%0d exp=2", lives); end
    total++; if (state !== 2'b01) begin bad++; $display("FAIL tickhit_state got=%b exp=01", state); end
  endtask

  task automatic test_blink_recovery();
    apply_reset();
    crash_frame();
    step();
    frame_tick = 1'b0;
    // Crash counter is 0 here; three ticks bring it to 3.
    repeat (3) do_tick();
    rgb_in[2:0] = 3'b111;
    rgb_bg      = 3'b010;
    on_in       = 8'b0000_0001;
    video_on    = 1'b1;
    step();
    total++; if (rgb_out !== 3'b111) begin bad++; $display("FAIL blink_cnt3_visible got=%b exp=111", rgb_out); end
    do_tick();
    total++; if (rgb_out !== 3'b010) begin bad++; $display("FAIL blink_cnt4_hidden got=%b exp=010", rgb_out); end
    // Overlap on a CRASH tick, with restart held: both are ignored.
    on_in      = 8'b0000_0011;
    frame_tick = 1'b1;
    restart    = 1'b1;
    #1;
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL crash_overlap_pulse got=%b exp=0", collision); end
    step();
    frame_tick = 1'b0;
    step();
    total++; if (lives !== 2'd2) begin bad++; $display("FAIL crash_overlap_lives got=%0d exp=2", lives); end
    total++; if (state !== 2'b01) begin bad++; $display("FAIL crash_restart_ignored got=%b exp=01", state); end
    idle_inputs();
    // Counter is 5; 54 more ticks reach 59 and the state is still CRASH.
    repeat (54) do_tick();
    total++; if (state !== 2'b01) begin bad++; $display("FAIL recover_early got=%b exp=01", state); end
    do_tick();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL recover_state got=%b exp=00", state); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL recover_freeze got=%b exp=0", freeze); end
    total++; if (lives !== 2'd2) begin bad++; $display("FAIL recover_lives got=%0d exp=2", lives); end
  endtask

  task automatic test_game_over();
    logic [1:0] exp_lives;
    logic [1:0] exp_state;
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      exp_lives = 2'(2 - k);
      exp_state = (k == 2) ? 2'b10 : 2'b00;
      crash_frame();
      total++; if (collision !== 1'b1) begin bad++; $display("FAIL over_pulse%0d got=%b exp=1", k, collision); end
      step();
      frame_tick = 1'b0;
      step();
      total++; if (lives !== exp_lives) begin bad++; $display("FAIL over_lives%0d got=%0d exp=%0d", k, lives, exp_lives); end
      repeat (60) do_tick();
      total++; if (state !== exp_state) begin bad++; $display("FAIL over_state%0d got=%b exp=%b", k, state, exp_state); end
    end
    total++; if (freeze !== 1'b1) begin bad++; $display("FAIL over_freeze got=%b exp=1", freeze); end
    video_on   = 1'b1;
    on_in      = 8'b0000_0101;
    frame_tick = 1'b1;
    #1;
    total++; if (collision !== 1'b0) begin bad++; $display("FAIL over_no_pulse got=%b exp=0", collision); end
    step();
    idle_inputs();
    repeat (3) do_tick();
    total++; if (state !== 2'b10) begin bad++; $display("FAIL over_hold got=%b exp=10", state); end
    total++; if (lives !== 2'd0) begin bad++; $display("FAIL over_lives_floor got=%0d exp=0", lives); end
    restart = 1'b1;
    step();
    restart = 1'b0;
    #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL restart_state got=%b exp=00", state); end
    total++; if (lives !== 2'd3) begin bad++; $display("FAIL restart_lives got=%0d exp=3", lives); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL restart_freeze got=%b exp=0", freeze); end
  endtask

  task automatic test_async_reset();
    apply_reset();
    crash_frame();
    step();
    frame_tick = 1'b0;
    repeat (30) do_tick();
    total++; if (state !== 2'b01) begin bad++; $display("FAIL areset_precond got=%b exp=01", state); end
    video_on = 1'b1;
    rgb_bg   = 3'b011;
    step();
    total++; if (rgb_out !== 3'b011) begin bad++; $display("FAIL areset_rgb_pre got=%b exp=011", rgb_out); end
    // Assert reset between clock edges and check before any edge arrives.
    #2;
    reset = 1'b1;
    #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL areset_state got=%b exp=00", state); end
    total++; if (lives !== 2'd3) begin bad++; $display("FAIL areset_lives got=%0d exp=3", lives); end
    total++; if (freeze !== 1'b0) begin bad++; $display("FAIL areset_freeze got=%b exp=0", freeze); end
    total++; if (rgb_out !== 3'b000) begin bad++; $display("FAIL areset_rgb got=%b exp=000", rgb_out); end
    reset = 1'b0;
    idle_inputs();
    step();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_priority();
    test_crash_entry();
    test_tick_hit();
    test_blink_recovery();
    test_game_over();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
